// File: rtl/mont_pkg.sv
// Shared constants, types and helpers for the Montgomery reduction pipeline.
// The optional canonicalising output stage is enabled by defining MONT_CANON_EN.
package mont_pkg;

    // Dilithium defaults: R = 2^32, Q = 8380417, QINV = Q^-1 mod 2^32
    localparam int     DIL_W    = 32;
    localparam longint DIL_Q    = 64'sd8380417;
    localparam longint DIL_QINV = 64'sd58728449;

    // Operand (2W bits) and coefficient (W bits) at the default width
    typedef logic signed [2*DIL_W-1:0] mont_operand_t;
    typedef logic signed [DIL_W-1:0]   mont_coeff_t;

    // Cycles from acceptance to RTS: three arithmetic stages, plus one when the
    // result is folded into [0, Q)
    function automatic int mont_latency(input bit canon);
        return canon ? 4 : 3;
    endfunction

endpackage

// File: rtl/mont_canon_stage.sv
// Optional output stage that maps a signed Montgomery result from (-Q, Q) into
// [0, Q). Instantiated by montgomery_reduce_pipe only when MONT_CANON_EN is defined.
module mont_canon_stage
    import mont_pkg::*;
#(
    parameter int     W         = DIL_W,
    parameter longint Q         = DIL_Q,
    parameter int     TAG_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 valid_in,
    input  logic signed [W-1:0]  t_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 valid,
    output logic signed [W-1:0]  t,
    output logic [TAG_WIDTH-1:0] tag
);

    localparam logic signed [W-1:0] Q_W = W'(Q);

    // Negative inputs lie in (-Q, 0), so a single add of Q lands them in (0, Q)
    logic signed [W-1:0] t_next;
    assign t_next = (t_in < 0) ? (t_in + Q_W) : t_in;

    // Output register: holds while stalled, loads data only for valid inputs
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            t     <= '0;
            tag   <= '0;
        end else if (en) begin
            valid <= valid_in;
            if (valid_in) begin
                t   <= t_next;
                tag <= tag_in;
            end
        end
    end

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// Fully pipelined Montgomery reduction t = a * 2^-W mod Q, one result per cycle,
// with a valid/ready handshake and a tag riding alongside each operand.
// Define MONT_CANON_EN to append a stage that returns results in [0, Q).
module montgomery_reduce_pipe
    import mont_pkg::*;
#(
    parameter int     W         = DIL_W,
    parameter longint Q         = DIL_Q,
    parameter longint QINV      = DIL_QINV,
    parameter int     TAG_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  RTR,
    input  logic signed [2*W-1:0] a,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  in_ready,
    output logic                  RTS,
    output logic signed [W-1:0]   t,
    output logic [TAG_WIDTH-1:0]  tag_out,
    input  logic                  ACK
);

    localparam logic [W-1:0]          QINV_W = W'(QINV);
    localparam logic signed [2*W-1:0] Q_WIDE = (2*W)'(Q);

    // One global enable: the whole pipe freezes only when a result is waiting
    // and downstream refuses it; bubbles otherwise flow through freely.
    logic en;
    assign en       = !(RTS && !ACK);
    assign in_ready = en;

    // valid_reg[0..2] = S1..S3
    logic [2:0] valid_reg;

    logic signed [2*W-1:0] s1_a_reg;
    logic [TAG_WIDTH-1:0]  s1_tag_reg;
    logic signed [W-1:0]   s1_m_reg;
    logic [W-1:0]          s1_m_next;

    logic signed [2*W-1:0] s2_a_reg;
    logic [TAG_WIDTH-1:0]  s2_tag_reg;
    logic signed [2*W-1:0] s2_p_reg;
    logic signed [2*W-1:0] s1_m_ext;
    logic signed [2*W-1:0] s2_p_next;

    logic signed [2*W-1:0] s3_diff;
    logic signed [W-1:0]   s3_t_next;
    logic signed [W-1:0]   s3_t_reg;
    logic [TAG_WIDTH-1:0]  s3_tag_reg;

    // m = a * QINV mod 2^W; only the low word of a can influence it
    assign s1_m_next = a[W-1:0] * QINV_W;

    // |m| < 2^(W-1) and Q < 2^(W-1), so the 2W-bit signed product is exact
    assign s1_m_ext  = {{W{s1_m_reg[W-1]}}, s1_m_reg};
    assign s2_p_next = s1_m_ext * Q_WIDE;

    // a - p is a multiple of 2^W; the arithmetic shift drops an all-zero low word
    assign s3_diff   = s2_a_reg - s2_p_reg;
    assign s3_t_next = W'(s3_diff >>> W);

    // Stage valid bits shift together under the global enable
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= '0;
        end else if (en) begin
            valid_reg <= {valid_reg[1:0], RTR};
        end
    end

    // S1: capture accepted operand, its tag and the Montgomery multiplier m
    always_ff @(posedge clock) begin
        if (en && RTR) begin
            s1_a_reg   <= a;
            s1_tag_reg <= tag_in;
            s1_m_reg   <= s1_m_next;
        end
    end

    // S2: form p = m * Q and carry the operand and tag forward
    always_ff @(posedge clock) begin
        if (en && valid_reg[0]) begin
            s2_a_reg   <= s1_a_reg;
            s2_tag_reg <= s1_tag_reg;
            s2_p_reg   <= s2_p_next;
        end
    end

    // S3: reduced result in (-Q, Q); cleared on reset so no stale value shows
    always_ff @(posedge clock) begin
        if (reset) begin
            s3_t_reg   <= '0;
            s3_tag_reg <= '0;
        end else if (en && valid_reg[1]) begin
            s3_t_reg   <= s3_t_next;
            s3_tag_reg <= s2_tag_reg;
        end
    end

`ifdef MONT_CANON_EN
    mont_canon_stage #(
        .W         (W),
        .Q         (Q),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_canon (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .valid_in (valid_reg[2]),
        .t_in     (s3_t_reg),
        .tag_in   (s3_tag_reg),
        .valid    (RTS),
        .t        (t),
        .tag      (tag_out)
    );
`else
    assign RTS     = valid_reg[2];
    assign t       = s3_t_reg;
    assign tag_out = s3_tag_reg;
`endif

endmodule

// File: doc/montgomery_reduce_pipe.md
Name: montgomery_reduce_pipe

Overview:
Fully pipelined, parametrised Montgomery reduction: computes t ≡ a·2^-W mod Q, one result per cycle, with a valid/ready handshake and a tag carried alongside each operand.
It generalises the fixed 32-bit multi-cycle reducer to any word width W and modulus Q.
It sits behind the NTT butterfly and pointwise multipliers in key generation, where back-to-back coefficients must reduce without idle cycles.

Parameters:
W, 32, reduction word width; R = 2^W; input is 2W bits, output W bits
Q, 8380417, odd modulus, Q < 2^(W-1)
QINV, 58728449, Q^-1 mod 2^W; must satisfy Q·QINV ≡ 1 mod 2^W
TAG_WIDTH, 8, width of the sideband tag passed through with each operand

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
RTR  in  1  input valid; operand a and tag_in are accepted when RTR && in_ready
a  in  2W signed  operand; caller guarantees |a| < Q·2^(W-1)
tag_in  in  TAG_WIDTH  sideband tag for a
in_ready  out  1  pipeline can accept an operand this cycle
RTS  out  1  output valid
t  out  W signed  reduced result
tag_out  out  TAG_WIDTH  tag matching t
ACK  in  1  downstream ready; result consumed when RTS && ACK

Behaviour:
- Reset (sync, active-high): all stage valid bits = 0; RTS = 0, t = 0, tag_out = 0. in_ready = 1 the cycle after reset deasserts. Reset mid-operation discards all in-flight operands, with no partial output.
- Stage S1 (register): m = low W bits of a[W-1:0]·QINV, treated as signed W-bit. Register a and tag alongside m.
- Stage S2 (register): p = m·Q, signed 2W bits. Carry a and tag forward.
- Stage S3 (register, output): t = (a − p) >>> W (arithmetic shift). The low W bits of a − p are zero by construction. Result lies in (−Q, Q).
- Latency: 3 cycles from acceptance to RTS with no stall; 4 with MONT_CANON_EN.
- Throughput: 1 operand/cycle while ACK = 1.
- Stall: global enable en = !(RTS && !ACK). in_ready = en.
  - When en = 0, every stage holds its data and valid bit, and t/tag_out stay stable.
  - Bubbles (valid = 0) advance normally.
- Simultaneous accept and output in one cycle is legal whenever ACK = 1.
- RTR while in_ready = 0: the operand is not accepted. Upstream holds a and tag_in.
- Invalid stages keep stale data. Only the valid bits are reset. The t and tag_out registers reset to 0.
- Products use full-width signed multiplies, with no truncation before the final shift.

Optional Feature:
Macro MONT_CANON_EN.
- Defined: adds stage S4, which outputs t + Q if t < 0, else t. Result lies in [0, Q). Latency becomes 4, with the same stall and handshake rules.
- Undefined: S3 drives outputs directly. Result lies in (−Q, Q). Latency 3.

Decomposition:
- Package mont_pkg holds:
  - Default constants DIL_Q = 8380417, DIL_QINV = 58728449, DIL_W = 32.
  - Function mont_latency(canon) returning 3 or 4.
  - Typedefs for the 2W-bit operand and W-bit coefficient.
- Sub-module mont_canon_stage holds the optional S4 register-plus-correction stage, with ports en, valid, t, tag. It is instantiated only under MONT_CANON_EN.

Test Plan:
- a = 0, a = 2^32, a = Q, a = −2^32, one per cycle, ACK = 1 -> after 3 cycles t = 0, 1, 0, −1 on consecutive cycles; tags match inputs; with MONT_CANON_EN, results are 0, 1, 0, 8380416 after 4 cycles.
- 1000 random a with |a| < Q·2^31, back-to-back, ACK = 1 -> each t·2^32 ≡ a mod Q; t in (−Q, Q); RTS continuous, no bubbles.
- 8 back-to-back operands; ACK = 0 for 3 cycles once RTS rises -> in_ready = 0 during the stall; t/tag_out held; no loss or duplication; order preserved.
- RTR toggling 1,0,1,1,0 with ACK = 1 -> bubbles propagate; RTS pattern equals the RTR pattern delayed by the latency.
- Assert reset for 1 cycle with 3 operands in flight -> next cycle RTS = 0, t = 0, tag_out = 0; no stale result ever appears; a new operand after reset yields the correct t at latency.
- Parameter override W = 16, Q = 3329, QINV = 62209 (Kyber), a = 2^16 -> t = 1; a = −2^16 -> t = −1 (3328 with MONT_CANON_EN).
